// File: rtl/rv32e_mem_arbiter_pkg.sv
// Shared types for the RV32E instruction/data memory arbiter.
package rv32e_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rv32e_mem_arbiter_if.sv
// Core-side fetch/load-store ports and downstream bus port of the memory arbiter.
interface rv32e_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [BE_W-1:0]   bus_be;
  logic              bus_ready;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  // Arbiter view: it masters the downstream bus.
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
           bus_ready, bus_rvalid, bus_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err,
           d_gnt, d_rvalid, d_rdata, d_err,
           bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );

  // Environment view: core requesters and downstream memory.
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
           bus_ready, bus_rvalid, bus_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err,
           d_gnt, d_rvalid, d_rdata, d_err,
           bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );

endinterface

// File: rtl/rv32e_mem_arbiter_prio.sv
// Data-over-instruction priority select with a starvation guard for fetches.
module rv32e_arb_prio
  import rv32e_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  input  logic arb_en,
  output logic win_i,
  output logic win_d
);

  localparam int unsigned SC_W = cnt_width(STARVE_LIMIT);

  logic [SC_W-1:0] starve_cnt;
  logic            d_first;

  assign d_first = d_req && (starve_cnt < SC_W'(STARVE_LIMIT));

  always_comb begin
    win_i = 1'b0;
    win_d = 1'b0;
    if (arb_en) begin
      if (d_first)    win_d = 1'b1;
      else if (i_req) win_i = 1'b1;
      else if (d_req) win_d = 1'b1;
    end
  end

  // Counts data wins over a waiting fetch; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (win_i) begin
      starve_cnt <= '0;
    end else if (win_d && i_req && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rv32e_mem_arbiter.sv
// Shares one single-ported bus between RV32E fetch and load/store ports, one transaction in flight.
// Optional WAIT timeout response enabled by defining RV32E_MEM_ARB_TIMEOUT_EN.
module rv32e_mem_arbiter
  import rv32e_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  rv32e_mem_arbiter_if.master mif,
  output logic                busy
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e        state;
  arb_owner_e        owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic resp;
  logic timeout;
  logic arb_en;
  logic win_i;
  logic win_d;

  assign resp   = (state == ARB_WAIT) && mif.bus_rvalid;
  assign arb_en = rst_n && ((state == ARB_IDLE) || resp);

  rv32e_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (mif.i_req),
    .d_req (mif.d_req),
    .arb_en(arb_en),
    .win_i (win_i),
    .win_d (win_d)
  );

`ifdef RV32E_MEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt;

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle that sees no response.
  assign timeout = (state == ARB_WAIT) && !mif.bus_rvalid &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != ARB_WAIT) begin
      tmo_cnt <= '0;
    end else if (!mif.bus_rvalid && !timeout) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      owner   <= OWN_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      case (state)
        ARB_ISSUE: begin
          if (mif.bus_ready) state <= ARB_WAIT;
        end
        ARB_IDLE, ARB_WAIT: begin
          // Winners only exist in IDLE or on a WAIT response, so one capture path serves both.
          if (win_i || win_d) begin
            state   <= ARB_ISSUE;
            owner   <= win_d ? OWN_D : OWN_I;
            we_q    <= win_d && mif.d_we;
            addr_q  <= win_d ? mif.d_addr : mif.i_addr;
            wdata_q <= win_d ? mif.d_wdata : '0;
            be_q    <= win_d ? mif.d_be : '1;
          end else if (resp || timeout) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign mif.i_gnt     = win_i;
  assign mif.d_gnt     = win_d;

  assign mif.i_rvalid  = (resp || timeout) && (owner == OWN_I);
  assign mif.d_rvalid  = (resp || timeout) && (owner == OWN_D);
  assign mif.i_rdata   = (resp && (owner == OWN_I)) ? mif.bus_rdata : '0;
  assign mif.d_rdata   = (resp && (owner == OWN_D)) ? mif.bus_rdata : '0;
  assign mif.i_err     = timeout && (owner == OWN_I);
  assign mif.d_err     = timeout && (owner == OWN_D);

  assign mif.bus_req   = (state == ARB_ISSUE);
  assign mif.bus_we    = we_q;
  assign mif.bus_addr  = addr_q;
  assign mif.bus_wdata = wdata_q;
  assign mif.bus_be    = be_q;

  assign busy          = (state != ARB_IDLE);

endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// Directed self-checking bench for rv32e_mem_arbiter (build with RV32E_MEM_ARB_TIMEOUT_EN for timeout case).
module tb_rv32e_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  rv32e_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  rv32e_mem_arbiter #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mif  (bif.master),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    bif.i_req = 0; bif.i_addr = '0;
    bif.d_req = 0; bif.d_we = 0; bif.d_addr = '0; bif.d_wdata = '0; bif.d_be = '0;
    bif.bus_ready = 0; bif.bus_rvalid = 0; bif.bus_rdata = '0;

    // Reset state, including with requests present
    next_cycle(); bif.i_req = 1; bif.d_req = 1; #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_bus_req", 32'(bif.bus_req), 0);
    check("rst_gnt", {30'd0, bif.i_gnt, bif.d_gnt}, 0);
    check("rst_bus_addr", bif.bus_addr, 0);
    check("rst_bus_be", 32'(bif.bus_be), 0);
    bif.i_req = 0; bif.d_req = 0;
    next_cycle(); rst_n = 1;

    // 1: single fetch, gnt@T, bus_req@T+1, rvalid@T+2
    next_cycle(); bif.i_req = 1; bif.i_addr = 32'h8000_0000; #1;
    check("t1_i_gnt", 32'(bif.i_gnt), 1);
    check("t1_d_gnt", 32'(bif.d_gnt), 0);
    check("t1_bus_req_T", 32'(bif.bus_req), 0);
    next_cycle(); bif.i_req = 0; bif.bus_ready = 1; #1;
    check("t1_bus_req", 32'(bif.bus_req), 1);
    check("t1_bus_addr", bif.bus_addr, 32'h8000_0000);
    check("t1_bus_we", 32'(bif.bus_we), 0);
    check("t1_bus_be", 32'(bif.bus_be), 32'hF);
    check("t1_busy", 32'(busy), 1);
    next_cycle(); bif.bus_ready = 0; bif.bus_rvalid = 1; bif.bus_rdata = 32'h0000_0013; #1;
    check("t1_i_rvalid", 32'(bif.i_rvalid), 1);
    check("t1_i_rdata", bif.i_rdata, 32'h13);
    check("t1_d_rvalid", 32'(bif.d_rvalid), 0);
    check("t1_bus_req_wait", 32'(bif.bus_req), 0);
    next_cycle(); bif.bus_rvalid = 0; #1;
    check("t1_idle", 32'(busy), 0);
    check("t1_rvalid_clr", 32'(bif.i_rvalid), 0);

    // 2: simultaneous requests, data wins, fetch granted on d_rvalid cycle
    next_cycle();
    bif.i_req = 1; bif.i_addr = 32'h200;
    bif.d_req = 1; bif.d_we = 1; bif.d_addr = 32'h100; bif.d_wdata = 32'hDEAD_BEEF; bif.d_be = 4'hF; #1;
    check("t2_d_gnt", 32'(bif.d_gnt), 1);
    check("t2_i_gnt", 32'(bif.i_gnt), 0);
    next_cycle(); bif.d_req = 0; bif.bus_ready = 1; #1;
    check("t2_bus_we", 32'(bif.bus_we), 1);
    check("t2_bus_addr", bif.bus_addr, 32'h100);
    check("t2_bus_wdata", bif.bus_wdata, 32'hDEAD_BEEF);
    check("t2_i_gnt_issue", 32'(bif.i_gnt), 0);
    next_cycle(); bif.bus_ready = 0; bif.bus_rvalid = 1; bif.bus_rdata = 32'h0; #1;
    check("t2_d_rvalid", 32'(bif.d_rvalid), 1);
    check("t2_i_rvalid", 32'(bif.i_rvalid), 0);
    check("t2_i_gnt", 32'(bif.i_gnt), 1);
    next_cycle(); bif.i_req = 0; bif.bus_rvalid = 0; bif.bus_ready = 1; #1;
    check("t2_f_bus_addr", bif.bus_addr, 32'h200);
    check("t2_f_bus_we", 32'(bif.bus_we), 0);
    check("t2_f_bus_wdata", bif.bus_wdata, 32'h0);
    next_cycle(); bif.bus_ready = 0; bif.bus_rvalid = 1; bif.bus_rdata = 32'h55; #1;
    check("t2_f_rvalid", {30'd0, bif.i_rvalid, bif.d_rvalid}, 32'b10);
    check("t2_f_rdata", bif.i_rdata, 32'h55);
    next_cycle(); bif.bus_rvalid = 0; #1;
    check("t2_idle", 32'(busy), 0);

    // 3: both held, memory always ready/responding: D D D D I repeating
    begin
      int unsigned n = 0;
      bif.d_we = 0; bif.d_addr = 32'h400;
      for (int c = 0; c < 20; c++) begin
        next_cycle();
        bif.i_req = 1; bif.d_req = 1; bif.bus_ready = 1; bif.bus_rvalid = 1; #1;
        if (bif.i_gnt || bif.d_gnt) begin
          check("t3_grant", {30'd0, bif.i_gnt, bif.d_gnt}, (n % 5 == 4) ? 32'b10 : 32'b01);
          n++;
        end
      end
      check("t3_grant_count", n, 10);
      next_cycle(); bif.i_req = 0; bif.d_req = 0; #1;
      check("t3_last_rvalid", 32'(bif.i_rvalid), 1);
      next_cycle(); bif.bus_ready = 0; bif.bus_rvalid = 0; #1;
      check("t3_idle", 32'(busy), 0);
    end

    // 4: bus_ready low for 5 cycles in ISSUE
    next_cycle();
    bif.d_req = 1; bif.d_we = 1; bif.d_addr = 32'h44; bif.d_wdata = 32'h1234_5678; bif.d_be = 4'h3; #1;
    check("t4_d_gnt", 32'(bif.d_gnt), 1);
    for (int k = 0; k < 5; k++) begin
      next_cycle(); bif.d_addr = 32'h48; bif.d_wdata = 32'hFFFF_0000; #1;
      check("t4_bus_req", 32'(bif.bus_req), 1);
      check("t4_bus_addr", bif.bus_addr, 32'h44);
      check("t4_bus_wdata", bif.bus_wdata, 32'h1234_5678);
      check("t4_bus_be", 32'(bif.bus_be), 32'h3);
      check("t4_no_gnt", {30'd0, bif.i_gnt, bif.d_gnt}, 0);
    end
    next_cycle(); bif.d_req = 0; bif.bus_ready = 1; #1;
    check("t4_accept_addr", bif.bus_addr, 32'h44);
    next_cycle(); bif.bus_ready = 0; bif.bus_rvalid = 1; #1;
    check("t4_d_rvalid", 32'(bif.d_rvalid), 1);
    next_cycle(); bif.bus_rvalid = 0; #1;
    check("t4_idle", 32'(busy), 0);

    // 5: reset while in WAIT, late response ignored
    next_cycle(); bif.i_req = 1; bif.i_addr = 32'h300; #1;
    check("t5_i_gnt", 32'(bif.i_gnt), 1);
    next_cycle(); bif.i_req = 0; bif.bus_ready = 1; #1;
    next_cycle(); bif.bus_ready = 0; #1;
    check("t5_in_wait", 32'(busy), 1);
    rst_n = 0; #1;
    check("t5_rst_busy", 32'(busy), 0);
    next_cycle(); rst_n = 1; bif.bus_rvalid = 1; bif.bus_rdata = 32'h77; #1;
    check("t5_no_rvalid", {30'd0, bif.i_rvalid, bif.d_rvalid}, 0);
    check("t5_busy", 32'(busy), 0);
    next_cycle(); bif.bus_rvalid = 0; #1;
    check("t5_still_idle", 32'(busy), 0);

    // 6: no response in WAIT
    next_cycle(); bif.d_req = 1; bif.d_we = 0; bif.d_addr = 32'h500; bif.d_be = 4'hF; #1;
    check("t6_d_gnt", 32'(bif.d_gnt), 1);
    next_cycle(); bif.d_req = 0; bif.bus_ready = 1; #1;
    next_cycle(); bif.bus_ready = 0; bif.bus_rdata = 32'hAAAA_AAAA;
`ifdef RV32E_MEM_ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      if (k != 0) next_cycle();
      #1;
      if (k < 7) begin
        check("t6_wait_rvalid", 32'(bif.d_rvalid), 0);
        check("t6_wait_busy", 32'(busy), 1);
      end else begin
        check("t6_tmo_rvalid", 32'(bif.d_rvalid), 1);
        check("t6_tmo_err", 32'(bif.d_err), 1);
        check("t6_tmo_rdata", bif.d_rdata, 32'h0);
        check("t6_tmo_i_rvalid", 32'(bif.i_rvalid), 0);
      end
    end
    next_cycle(); #1;
    check("t6_tmo_idle", 32'(busy), 0);
    check("t6_err_clr", 32'(bif.d_err), 0);
`else
    for (int k = 0; k < 12; k++) begin
      if (k != 0) next_cycle();
      #1;
      check("t6_busy_held", 32'(busy), 1);
      check("t6_no_rvalid", 32'(bif.d_rvalid), 0);
      check("t6_err_zero", {30'd0, bif.i_err, bif.d_err}, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
